// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and the dump FSM state
// encoding used by the register-file read-out engine.
package cpu_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    // Dump engine state encoding (also visible on the debug state port).
    typedef enum logic [1:0] {
        DUMP_IDLE = 2'd0,
        DUMP_WAIT = 2'd1,
        DUMP_SEND = 2'd2
    } dump_state_e;

    // Width of a down-counter that must hold the value read_wait.
    function automatic int wait_ctr_width(input int read_wait);
        return (read_wait < 2) ? 1 : $clog2(read_wait + 1);
    endfunction

endpackage

// File: rtl/dump_addr_ctr.sv
// Loadable wrap-around register address counter. Latches the last address
// of the range on load and keeps a registered flag telling whether the
// current address is that last address, so the FSM never needs a wide
// compare on its own decision path.
module dump_addr_ctr
    import cpu_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] first_addr_i,
    input  logic [ADDR_W-1:0] last_addr_i,
    input  logic              inc_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              is_last_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic              is_last_q, is_last_d;

    // Next address: load the range start, or step by one with natural wrap.
    always_comb begin
        addr_d    = addr_q;
        last_d    = last_q;
        is_last_d = is_last_q;
        if (load_i) begin
            addr_d    = first_addr_i;
            last_d    = last_addr_i;
            is_last_d = (first_addr_i == last_addr_i);
        end else if (inc_i) begin
            addr_d    = addr_q + ADDR_W'(1);
            is_last_d = (addr_d == last_q);
        end
    end

    // Address, latched range end and last-address flag registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q    <= '0;
            last_q    <= '0;
            is_last_q <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            last_q    <= last_d;
            is_last_q <= is_last_d;
        end
    end

    assign addr_o    = addr_q;
    assign is_last_o = is_last_q;

endmodule

// File: rtl/regfile_dump_reader.sv
// Register-file dump engine. On START it walks FIRST_ADDR..LAST_ADDR
// (wrapping 31 -> 0) through one read port, waits READ_WAIT cycles for the
// asynchronous read path to settle, captures each word and presents it as
// an (address, data) pair. HOLD_WRITES stays high for the whole walk so the
// CPU cannot change the register file underneath the snapshot.
//
// Handshake: DUMP_ADDR/DUMP_DATA are valid while DUMP_VALID is high and hold
// stable until a rising edge sees DUMP_VALID && DUMP_READY; that edge is the
// transfer. DUMP_VALID never drops without a transfer except on reset, and
// DUMP_READY has no effect while DUMP_VALID is low.
module regfile_dump_reader
    import cpu_pkg::*;
#(
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter int READ_WAIT = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              START,
    input  logic [ADDR_W-1:0] FIRST_ADDR,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic [ADDR_W-1:0] RF_ADDR,
    input  logic [DATA_W-1:0] RF_DATA,
    output logic [ADDR_W-1:0] DUMP_ADDR,
    output logic [DATA_W-1:0] DUMP_DATA,
    output logic              DUMP_VALID,
    input  logic              DUMP_READY,
    output logic              BUSY,
    output logic              HOLD_WRITES,
    output logic              DONE,
    output logic [1:0]        DBG_STATE
);

    localparam int              CNT_W     = wait_ctr_width(READ_WAIT);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_WAIT);

    dump_state_e       state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] dump_addr_q;
    logic [DATA_W-1:0] dump_data_q;
    logic              dump_valid_q;
    logic              busy_q;
    logic              done_q;

    logic              ctr_load;
    logic              ctr_inc;
    logic              is_last;
    logic [ADDR_W-1:0] rf_addr;

    // Range is loaded only when a START is accepted; the address steps only
    // on a transfer that is not the final word.
    assign ctr_load = (state_q == DUMP_IDLE) && START;
    assign ctr_inc  = (state_q == DUMP_SEND) && DUMP_READY && !is_last;

    dump_addr_ctr #(
        .ADDR_W(ADDR_W)
    ) u_addr_ctr (
        .clk_i        (CLK),
        .rst_ni       (RESET),
        .load_i       (ctr_load),
        .first_addr_i (FIRST_ADDR),
        .last_addr_i  (LAST_ADDR),
        .inc_i        (ctr_inc),
        .addr_o       (rf_addr),
        .is_last_o    (is_last)
    );

    // Dump FSM: IDLE -> WAIT (read settles) -> SEND (handshake) -> WAIT/IDLE.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q      <= DUMP_IDLE;
            cnt_q        <= '0;
            dump_addr_q  <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                DUMP_IDLE: begin
                    if (START) begin
                        cnt_q   <= WAIT_LOAD;
                        busy_q  <= 1'b1;
                        state_q <= DUMP_WAIT;
                    end
                end
                DUMP_WAIT: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end else begin
                        dump_data_q  <= RF_DATA;
                        dump_addr_q  <= rf_addr;
                        dump_valid_q <= 1'b1;
                        state_q      <= DUMP_SEND;
                    end
                end
                DUMP_SEND: begin
                    if (DUMP_READY) begin
                        dump_valid_q <= 1'b0;
                        if (is_last) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= DUMP_IDLE;
                        end else begin
                            cnt_q   <= WAIT_LOAD;
                            state_q <= DUMP_WAIT;
                        end
                    end
                end
                default: begin
                    dump_valid_q <= 1'b0;
                    busy_q       <= 1'b0;
                    state_q      <= DUMP_IDLE;
                end
            endcase
        end
    end

    assign RF_ADDR     = rf_addr;
    assign DUMP_ADDR   = dump_addr_q;
    assign DUMP_DATA   = dump_data_q;
    assign DUMP_VALID  = dump_valid_q;
    assign BUSY        = busy_q;
    assign HOLD_WRITES = (state_q != DUMP_IDLE);
    assign DONE        = done_q;
    assign DBG_STATE   = state_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Bench for the register-file dump engine: a delayed-read register file
// model with write gating, a cycle model of the dump protocol with an
// expected queue, per-cycle comparison and directed scenarios.
module tb_regfile_dump_reader;

    localparam int READ_WAIT = 1;
    localparam int GAP       = READ_WAIT + 1;

    // ---------------- clock / reset ----------------
    logic        CLK;
    logic        RESET;
    logic        START;
    logic [4:0]  FIRST_ADDR;
    logic [4:0]  LAST_ADDR;
    logic [4:0]  RF_ADDR;
    logic [31:0] RF_DATA;
    logic [4:0]  DUMP_ADDR;
    logic [31:0] DUMP_DATA;
    logic        DUMP_VALID;
    logic        DUMP_READY;
    logic        BUSY;
    logic        HOLD_WRITES;
    logic        DONE;
    logic [1:0]  DBG_STATE;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    regfile_dump_reader #(
        .ADDR_W(5), .DATA_W(32), .READ_WAIT(READ_WAIT)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .FIRST_ADDR(FIRST_ADDR), .LAST_ADDR(LAST_ADDR),
        .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA),
        .DUMP_ADDR(DUMP_ADDR), .DUMP_DATA(DUMP_DATA),
        .DUMP_VALID(DUMP_VALID), .DUMP_READY(DUMP_READY),
        .BUSY(BUSY), .HOLD_WRITES(HOLD_WRITES), .DONE(DONE),
        .DBG_STATE(DBG_STATE)
    );

    // ---------------- register file model ----------------
    logic [31:0] rf [32];
    logic        rf_init;
    logic        cpu_we;
    logic [4:0]  cpu_waddr;
    logic [31:0] cpu_wdata;
    logic [31:0] rf_now;

    always @(posedge CLK) begin
        if (rf_init) begin
            for (int i = 0; i < 32; i++) rf[i] <= 32'(i * 3);
        end else if (cpu_we && !HOLD_WRITES) begin
            rf[cpu_waddr] <= cpu_wdata;
        end
    end

    always_comb rf_now = rf[RF_ADDR];
    always @(rf_now) RF_DATA <= #2 rf_now;

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [36:0] exp_q[$];      // {addr, data} still to be transferred
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    bit          m_done  = 1'b0;
    int          m_left  = 0;
    bit          prev_valid = 1'b0;

    logic [4:0]  log_addr[$];
    logic [31:0] log_data[$];
    int          log_cyc[$];
    int          rise_cyc[$];
    int          start_cyc[$];
    int          done_cnt = 0;

    // Per-cycle compare against the protocol model, then advance the model
    // using the inputs that the upcoming rising edge will see.
    always @(negedge CLK) begin
        if (!RESET) begin
            chk("rst_rf_addr", 32'(RF_ADDR), 32'd0);
            chk("rst_valid", 32'(DUMP_VALID), 32'd0);
            chk("rst_busy", 32'(BUSY), 32'd0);
            chk("rst_done", 32'(DONE), 32'd0);
            exp_q.delete();
            m_busy = 1'b0; m_valid = 1'b0; m_done = 1'b0; m_left = 0;
            prev_valid = 1'b0;
        end else begin
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("hold_writes", 32'(HOLD_WRITES), 32'(m_busy));
            chk("done", 32'(DONE), 32'(m_done));
            chk("valid", 32'(DUMP_VALID), 32'(m_valid));
            if (DONE) done_cnt++;
            if (DUMP_VALID && !prev_valid) rise_cyc.push_back(cyc);
            prev_valid = DUMP_VALID;
            if (m_busy && exp_q.size() > 0) begin
                chk("rf_addr", 32'(RF_ADDR), 32'(exp_q[0][36:32]));
                if (m_valid) begin
                    chk("dump_addr", 32'(DUMP_ADDR), 32'(exp_q[0][36:32]));
                    chk("dump_data", DUMP_DATA, exp_q[0][31:0]);
                end
            end
            m_done = 1'b0;
            if (m_busy) begin
                if (m_valid) begin
                    if (DUMP_READY) begin
                        log_addr.push_back(DUMP_ADDR);
                        log_data.push_back(DUMP_DATA);
                        log_cyc.push_back(cyc + 1);
                        void'(exp_q.pop_front());
                        m_valid = 1'b0;
                        if (exp_q.size() == 0) begin
                            m_busy = 1'b0;
                            m_done = 1'b1;
                        end else begin
                            m_left = GAP;
                        end
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) m_valid = 1'b1;
                end
            end else if (START) begin
                int cnt;
                logic [4:0] a;
                cnt = ((int'(LAST_ADDR) - int'(FIRST_ADDR) + 32) % 32) + 1;
                for (int i = 0; i < cnt; i++) begin
                    a = 5'(int'(FIRST_ADDR) + i);
                    exp_q.push_back({a, rf[a]});
                end
                m_busy = 1'b1;
                m_left = GAP;
                start_cyc.push_back(cyc + 1);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_dump(input logic [4:0] f, input logic [4:0] l);
        FIRST_ADDR = f;
        LAST_ADDR  = l;
        START      = 1'b1;
        tick();
        START      = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (DONE !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(DONE === 1'b1), 32'd1);
    endtask

    task automatic wait_valid(input int budget, input string name);
        int n = 0;
        while (DUMP_VALID !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(name, 32'(DUMP_VALID === 1'b1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base;
        int dbase;
        RESET = 1'b0; START = 1'b0; FIRST_ADDR = '0; LAST_ADDR = '0;
        DUMP_READY = 1'b1; rf_init = 1'b1; cpu_we = 1'b0;
        cpu_waddr = '0; cpu_wdata = '0;
        tick(); tick(); tick();
        chk("reset_dump_addr", 32'(DUMP_ADDR), 32'd0);
        chk("reset_dump_data", DUMP_DATA, 32'd0);
        chk("reset_state", 32'(DBG_STATE), 32'd0);
        rf_init = 1'b0;
        RESET   = 1'b1;
        tick(); tick();

        // T1: range 0..3, READY tied high
        base = log_addr.size(); dbase = done_cnt;
        start_dump(5'd0, 5'd3);
        wait_done(40, "t1_done_seen");
        tick();
        chk("t1_count", 32'(log_addr.size() - base), 32'd4);
        chk("t1_a0", 32'(log_addr[base]), 32'd0);
        chk("t1_d1", log_data[base+1], 32'd3);
        chk("t1_d2", log_data[base+2], 32'd6);
        chk("t1_a3", 32'(log_addr[base+3]), 32'd3);
        chk("t1_d3", log_data[base+3], 32'd9);
        chk("t1_first_latency", 32'(rise_cyc[rise_cyc.size()-4] - start_cyc[start_cyc.size()-1]), 32'd2);
        chk("t1_spacing", 32'(log_cyc[base+1] - log_cyc[base]), 32'd3);
        chk("t1_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("t1_busy_after", 32'(BUSY), 32'd0);

        // T2: wrapping range 30..1, START issued in the DONE cycle
        base = log_addr.size();
        start_dump(5'd0, 5'd0);
        wait_done(20, "t2_pre_done_seen");
        start_dump(5'd30, 5'd1);
        wait_done(40, "t2_done_seen");
        tick();
        chk("t2_count", 32'(log_addr.size() - base), 32'd5);
        chk("t2_a0", 32'(log_addr[base+1]), 32'd30);
        chk("t2_d1", log_data[base+2], 32'd93);
        chk("t2_a2", 32'(log_addr[base+3]), 32'd0);
        chk("t2_d3", log_data[base+4], 32'd3);

        // T3: consumer stalls on word 2
        base = log_addr.size();
        start_dump(5'd0, 5'd3);
        wait_valid(10, "t3_w0_seen");
        tick();
        DUMP_READY = 1'b0;
        wait_valid(10, "t3_w1_seen");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid", 32'(DUMP_VALID), 32'd1);
            chk("t3_hold_addr", 32'(DUMP_ADDR), 32'd1);
            chk("t3_hold_data", DUMP_DATA, 32'd3);
            chk("t3_hold_rf_addr", 32'(RF_ADDR), 32'd1);
            tick();
        end
        DUMP_READY = 1'b1;
        tick();
        chk("t3_released", 32'(DUMP_VALID), 32'd0);
        chk("t3_xfer_count", 32'(log_addr.size() - base), 32'd2);
        wait_done(40, "t3_done_seen");
        tick();

        // T4: START while busy is ignored
        base = log_addr.size(); dbase = done_cnt;
        start_dump(5'd4, 5'd6);
        tick(); tick();
        start_dump(5'd10, 5'd10);
        wait_done(40, "t4_done_seen");
        for (int i = 0; i < 12; i++) tick();
        chk("t4_count", 32'(log_addr.size() - base), 32'd3);
        chk("t4_last_addr", 32'(log_addr[base+2]), 32'd6);
        chk("t4_one_done", 32'(done_cnt - dbase), 32'd1);

        // T5: asynchronous reset during WAIT of the first word
        base = log_addr.size(); dbase = done_cnt;
        start_dump(5'd8, 5'd12);
        #3;
        RESET = 1'b0;
        #1;
        chk("t5_async_rf_addr", 32'(RF_ADDR), 32'd0);
        chk("t5_async_busy", 32'(BUSY), 32'd0);
        chk("t5_async_hold", 32'(HOLD_WRITES), 32'd0);
        chk("t5_async_state", 32'(DBG_STATE), 32'd0);
        tick(); tick();
        RESET = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("t5_no_words", 32'(log_addr.size() - base), 32'd0);
        chk("t5_no_done", 32'(done_cnt - dbase), 32'd0);
        start_dump(5'd5, 5'd5);
        wait_done(20, "t5_single_done_seen");
        tick();
        chk("t5_single_count", 32'(log_addr.size() - base), 32'd1);
        chk("t5_single_addr", 32'(log_addr[base]), 32'd5);
        chk("t5_single_data", log_data[base], 32'd15);

        // T6: full 32-word dump with a blocked CPU write to r7
        base = log_addr.size();
        start_dump(5'd7, 5'd6);
        tick(); tick(); tick(); tick(); tick();
        cpu_we = 1'b1; cpu_waddr = 5'd7; cpu_wdata = 32'd999;
        chk("t6_hold_at_write", 32'(HOLD_WRITES), 32'd1);
        tick();
        cpu_we = 1'b0;
        wait_done(200, "t6_done_seen");
        tick();
        chk("t6_count", 32'(log_addr.size() - base), 32'd32);
        chk("t6_first", 32'(log_addr[base]), 32'd7);
        chk("t6_a31", 32'(log_addr[base+24]), 32'd31);
        chk("t6_wrap0", 32'(log_addr[base+25]), 32'd0);
        chk("t6_last", 32'(log_addr[base+31]), 32'd6);
        chk("t6_d_last", log_data[base+31], 32'd18);
        base = log_addr.size();
        start_dump(5'd7, 5'd7);
        wait_done(20, "t6_r7_done_seen");
        tick();
        chk("t6_r7_unchanged", log_data[base], 32'd21);
        chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
